// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop sync, per-channel debounce FSM, level + press/release strobes.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat press strobes.

module button_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam bit ONE = (DEBOUNCE_CYCLES == 1);
  // cnt holds the number of consecutive new-level samples seen so far
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_channel: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT_HI, PRESSED, WAIT_LO} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic level_n, press_n, rel_n, rep_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      press <= press_n;
      rel   <= rel_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (s) begin
        if (ONE) state_n = PRESSED;
        else begin state_n = WAIT_HI; cnt_n = CW'(1); end
      end
      WAIT_HI:
        if (!s)               begin state_n = IDLE;    cnt_n = '0; end
        else if (cnt == LAST) begin state_n = PRESSED; cnt_n = '0; end
        else                  cnt_n = cnt + CW'(1);
      PRESSED: if (!s) begin
        if (ONE) state_n = IDLE;
        else begin state_n = WAIT_LO; cnt_n = CW'(1); end
      end
      WAIT_LO:
        if (s)                begin state_n = PRESSED; cnt_n = '0; end
        else if (cnt == LAST) begin state_n = IDLE;    cnt_n = '0; end
        else                  cnt_n = cnt + CW'(1);
      default: begin state_n = IDLE; cnt_n = '0; end
    endcase
  end

  // Outputs are computed from the upcoming state so the registers line up with the transition
  always_comb begin
    level_n = (state_n == PRESSED) || (state_n == WAIT_LO);
    press_n = ((state_n == PRESSED) && (state == WAIT_HI || state == IDLE)) || rep_fire;
    rel_n   = (state_n == IDLE) && (state == WAIT_LO || state == PRESSED);
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  logic [RW-1:0] rcnt, rcnt_n;

  always_ff @(posedge clk) begin
    if (reset) rcnt <= '0;
    else       rcnt <= rcnt_n;
  end

  // Counts only while PRESSED is held; a WAIT_LO excursion freezes it
  always_comb begin
    rcnt_n   = rcnt;
    rep_fire = 1'b0;
    if (state == PRESSED && state_n == PRESSED) begin
      if (rcnt == RW'(REPEAT_DELAY + REPEAT_PERIOD - 1)) begin
        rcnt_n   = RW'(REPEAT_DELAY);
        rep_fire = 1'b1;
      end else begin
        rcnt_n   = rcnt + RW'(1);
        rep_fire = (rcnt == RW'(REPEAT_DELAY - 1));
      end
    end else if (state_n == PRESSED && state != PRESSED && state != WAIT_LO) begin
      rcnt_n = '0;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif
endmodule

module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  logic [N_BTN-1:0] s1, s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .s    (s2[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_button_conditioner;
  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release;
  int checks = 0;
  int failures = 0;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_raw = '0;
    tick();
    tick();
    checks++;
    if (btn_level !== 4'b0) begin failures++; $display("FAIL reset_level: got %b want 0000", btn_level); end
    checks++;
    if (btn_press !== 4'b0) begin failures++; $display("FAIL reset_press: got %b want 0000", btn_press); end
    checks++;
    if (btn_release !== 4'b0) begin failures++; $display("FAIL reset_release: got %b want 0000", btn_release); end
    reset = 1'b0;
  endtask

  // Raw goes high just before edge 1; acceptance lands on edge D+2 = 6
  task automatic test_clean_press();
    logic [3:0] el, ep;
    btn_raw = 4'b0010;
    for (int i = 1; i <= 15; i++) begin
      tick();
      el = (i >= D + 2) ? 4'b0010 : 4'b0000;
      ep = (i == D + 2) ? 4'b0010 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release} !== {el, ep, 4'b0000}) begin
        failures++;
        $display("FAIL clean_press[%0d]: level=%b press=%b release=%b want level=%b press=%b release=0000",
                 i, btn_level, btn_press, btn_release, el, ep);
      end
    end
  endtask

  task automatic test_release();
    logic [3:0] el, er;
    btn_raw = 4'b0000;
    for (int i = 1; i <= 10; i++) begin
      tick();
      el = (i >= D + 2) ? 4'b0000 : 4'b0010;
      er = (i == D + 2) ? 4'b0010 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release} !== {el, 4'b0000, er}) begin
        failures++;
        $display("FAIL release[%0d]: level=%b press=%b release=%b want level=%b press=0000 release=%b",
                 i, btn_level, btn_press, btn_release, el, er);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    logic [3:0] el, ep;
    pat = 6'b101101;  // applied MSB first: 1,0,1,1,0,1
    for (int i = 5; i >= 0; i--) begin
      btn_raw = {1'b0, pat[i], 2'b00};
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release} !== 12'h000) begin
        failures++;
        $display("FAIL bounce_toggle[%0d]: level=%b press=%b release=%b want all 0000",
                 5 - i, btn_level, btn_press, btn_release);
      end
    end
    // Final rise was sampled on the last toggle edge, so that edge counts as edge 1
    for (int i = 2; i <= 8; i++) begin
      tick();
      el = (i >= D + 2) ? 4'b0100 : 4'b0000;
      ep = (i == D + 2) ? 4'b0100 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release} !== {el, ep, 4'b0000}) begin
        failures++;
        $display("FAIL bounce_accept[%0d]: level=%b press=%b release=%b want level=%b press=%b release=0000",
                 i, btn_level, btn_press, btn_release, el, ep);
      end
    end
    btn_raw = '0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (btn_level !== 4'b0000) begin failures++; $display("FAIL bounce_cleanup: level=%b want 0000", btn_level); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] el, ep, er;
    btn_raw = 4'b1110;
    for (int i = 1; i <= 7; i++) begin
      tick();
      el = (i >= D + 2) ? 4'b1110 : 4'b0000;
      ep = (i == D + 2) ? 4'b1110 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release} !== {el, ep, 4'b0000}) begin
        failures++;
        $display("FAIL simul_press[%0d]: level=%b press=%b release=%b want level=%b press=%b release=0000",
                 i, btn_level, btn_press, btn_release, el, ep);
      end
    end
    btn_raw = 4'b0000;
    for (int i = 1; i <= 7; i++) begin
      tick();
      el = (i >= D + 2) ? 4'b0000 : 4'b1110;
      er = (i == D + 2) ? 4'b1110 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release} !== {el, 4'b0000, er}) begin
        failures++;
        $display("FAIL simul_release[%0d]: level=%b press=%b release=%b want level=%b press=0000 release=%b",
                 i, btn_level, btn_press, btn_release, el, er);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] el, ep;
    btn_raw = 4'b1000;
    for (int i = 0; i < 4; i++) tick();  // two edges into WAIT_HI
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release} !== 12'h000) begin
        failures++;
        $display("FAIL reset_mid_hold[%0d]: level=%b press=%b release=%b want all 0000",
                 i, btn_level, btn_press, btn_release);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      el = (i >= D + 2) ? 4'b1000 : 4'b0000;
      ep = (i == D + 2) ? 4'b1000 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release} !== {el, ep, 4'b0000}) begin
        failures++;
        $display("FAIL reset_mid_after[%0d]: level=%b press=%b release=%b want level=%b press=%b release=0000",
                 i, btn_level, btn_press, btn_release, el, ep);
      end
    end
    btn_raw = '0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (btn_level !== 4'b0000) begin failures++; $display("FAIL reset_mid_cleanup: level=%b want 0000", btn_level); end
  endtask

  task automatic test_autorepeat();
    logic [3:0] ep;
    bit rep;
    btn_raw = 4'b0001;
    for (int i = 1; i <= D + 2 + 20; i++) begin
      tick();
      rep = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep = (i - (D + 2) >= 10) && (((i - (D + 2) - 10) % 3) == 0);
`endif
      ep = ((i == D + 2) || rep) ? 4'b0001 : 4'b0000;
      checks++;
      if (btn_press !== ep) begin
        failures++;
        $display("FAIL autorepeat[%0d]: press=%b want %b", i, btn_press, ep);
      end
    end
    btn_raw = '0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (btn_level !== 4'b0000) begin failures++; $display("FAIL autorepeat_cleanup: level=%b want 0000", btn_level); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_autorepeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
